// File: rtl/z_core_writeback.sv
// Register-file writer: arbitrates LSU load returns and buffered/bypassed ALU
// results onto the single write port, and tracks pending destination registers.
module z_core_writeback #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_stall,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_rd_in,
  output logic            rf_write_enable
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]     pending_q, pending_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;
  logic            rf_we_q, rf_we_d;

  logic            fifo_empty;
  logic            alu_acc;
  logic            push;
  logic            pop;
  logic            commit;
  logic [4:0]      commit_rd;
  logic [XLEN-1:0] commit_data;
  logic            issue_fire;

  assign alu_ready  = (count_q < CNT_W'(FIFO_DEPTH));
  assign lsu_ready  = 1'b1;
  assign fifo_empty = (count_q == '0);
  assign alu_acc    = alu_valid & alu_ready;

  assign issue_stall = issue_valid & pending_q[issue_rd] & (issue_rd != '0);
  assign rs1_busy    = pending_q[rs1] & (rs1 != '0);
  assign rs2_busy    = pending_q[rs2] & (rs2 != '0);
  assign issue_fire  = issue_valid & ~issue_stall & (issue_rd != '0);

  assign rf_rd           = rf_rd_q;
  assign rf_rd_in        = rf_data_q;
  assign rf_write_enable = rf_we_q;

  // LSU wins; buffered ALU results drain before any new ALU result may bypass.
  always_comb begin
    commit      = 1'b0;
    commit_rd   = '0;
    commit_data = '0;
    pop         = 1'b0;
    push        = 1'b0;
    if (lsu_valid) begin
      commit      = 1'b1;
      commit_rd   = lsu_rd;
      commit_data = lsu_data;
      push        = alu_acc;
    end else if (!fifo_empty) begin
      commit      = 1'b1;
      commit_rd   = fifo_rd_q[rd_ptr_q];
      commit_data = fifo_data_q[rd_ptr_q];
      pop         = 1'b1;
      push        = alu_acc;
    end else if (alu_valid) begin
      commit      = 1'b1;
      commit_rd   = alu_rd;
      commit_data = alu_data;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rf_we_d   = commit & (commit_rd != '0);
    rf_rd_d   = commit ? commit_rd   : rf_rd_q;
    rf_data_d = commit ? commit_data : rf_data_q;
  end

  // Clear follows the registered write strobe so busy drops with the RF update.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) pending_d[rf_rd_q] = 1'b0;
    if (issue_fire) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= alu_rd;
      fifo_data_q[wr_ptr_q] <= alu_data;
    end
  end

endmodule

// File: tb/tb_z_core_writeback.sv
// Bench for z_core_writeback: queue model of the commit arbiter feeds an
// expected-write scoreboard; scenario tasks add directed inline checks.
module tb_z_core_writeback;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            issue_valid = 1'b0;
  logic [4:0]      issue_rd = '0;
  logic            issue_stall;
  logic [4:0]      rs1 = '0;
  logic [4:0]      rs2 = '0;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            alu_valid = 1'b0;
  logic            alu_ready;
  logic [4:0]      alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            lsu_valid = 1'b0;
  logic            lsu_ready;
  logic [4:0]      lsu_rd = '0;
  logic [XLEN-1:0] lsu_data = '0;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_rd_in;
  logic            rf_write_enable;

  always #5 clk = ~clk;

  z_core_writeback #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_rd(rf_rd), .rf_rd_in(rf_rd_in), .rf_write_enable(rf_write_enable)
  );

  typedef struct packed {logic we; logic [4:0] rd; logic [XLEN-1:0] data;} wr_t;
  typedef struct packed {logic [4:0] rd; logic [XLEN-1:0] data;} ent_t;

  wr_t             exp_q[$];
  ent_t            mfifo[$];
  logic [4:0]      m_rd = '0;
  logic [XLEN-1:0] m_data = '0;
  int unsigned     vectors = 0;
  int unsigned     miscompares = 0;

  // Model the cycle about to be clocked, queue the expected rf_* state, then clock.
  task automatic step();
    wr_t  e;
    ent_t head;
    bit   can_push;
    e = '0;
    can_push = (mfifo.size() < DEPTH);
    if (reset) begin
      mfifo.delete();
      m_rd = '0;
      m_data = '0;
    end else if (lsu_valid) begin
      m_rd = lsu_rd; m_data = lsu_data; e.we = (lsu_rd != 0);
      if (alu_valid && can_push) mfifo.push_back('{rd: alu_rd, data: alu_data});
    end else if (mfifo.size() > 0) begin
      head = mfifo.pop_front();
      m_rd = head.rd; m_data = head.data; e.we = (head.rd != 0);
      if (alu_valid && can_push) mfifo.push_back('{rd: alu_rd, data: alu_data});
    end else if (alu_valid) begin
      m_rd = alu_rd; m_data = alu_data; e.we = (alu_rd != 0);
    end
    e.rd = m_rd;
    e.data = m_data;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({rf_write_enable, rf_rd, rf_rd_in} !== {e.we, e.rd, e.data}) begin
        miscompares++;
        $display("FAIL rf_write: got we=%0b rd=%0d data=%h, expected we=%0b rd=%0d data=%h",
                 rf_write_enable, rf_rd, rf_rd_in, e.we, e.rd, e.data);
      end
    end
  end

  task automatic idle_inputs();
    issue_valid = 0; lsu_valid = 0; alu_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    step(); step();
    reset = 0; rs1 = 5'd1; rs2 = 5'd2; issue_valid = 1; issue_rd = 5'd1;
    #1;
    vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL reset_alu_ready got %b want 1", alu_ready); end
    vectors++; if (lsu_ready !== 1'b1) begin miscompares++; $display("FAIL reset_lsu_ready got %b want 1", lsu_ready); end
    vectors++; if ({rs1_busy, rs2_busy, issue_stall} !== 3'b000) begin miscompares++; $display("FAIL reset_busy got %b want 000", {rs1_busy, rs2_busy, issue_stall}); end
    vectors++; if (rf_write_enable !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", rf_write_enable); end
    issue_valid = 0;
    step();
  endtask

  task automatic test_single_alu();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h1234;
    #1;
    vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready got %b want 1", alu_ready); end
    step();
    alu_valid = 0;
    vectors++; if ({rf_write_enable, rf_rd, rf_rd_in} !== {1'b1, 5'd5, 32'h1234}) begin miscompares++; $display("FAIL single_write got we=%b rd=%0d data=%h want 1/5/1234", rf_write_enable, rf_rd, rf_rd_in); end
    step();
    vectors++; if (rf_write_enable !== 1'b0) begin miscompares++; $display("FAIL single_we_drop got %b want 0", rf_write_enable); end
  endtask

  task automatic test_collision();
    lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'hAAAA0000;
    alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h55;
    step();
    idle_inputs();
    vectors++; if ({rf_write_enable, rf_rd, rf_rd_in} !== {1'b1, 5'd3, 32'hAAAA0000}) begin miscompares++; $display("FAIL collision_lsu got we=%b rd=%0d data=%h", rf_write_enable, rf_rd, rf_rd_in); end
    step();
    vectors++; if ({rf_write_enable, rf_rd, rf_rd_in} !== {1'b1, 5'd4, 32'h55}) begin miscompares++; $display("FAIL collision_alu got we=%b rd=%0d data=%h", rf_write_enable, rf_rd, rf_rd_in); end
    step();
  endtask

  task automatic test_back_pressure();
    int unsigned idx = 0;
    bit acc;
    for (int c = 0; c < 10; c++) begin
      lsu_valid = (c < 4); lsu_rd = 5'(20 + c); lsu_data = 32'hB000_0000 + 32'(c);
      alu_valid = (idx < 3); alu_rd = 5'(6 + idx); alu_data = 32'h600 + 32'(idx);
      #1;
      if (c < 3) begin
        vectors++;
        if (alu_ready !== (c < 2)) begin miscompares++; $display("FAIL bp_ready[%0d] got %b want %b", c, alu_ready, (c < 2)); end
      end
      acc = alu_valid & alu_ready;
      step();
      if (acc) idx++;
      if (c >= 4 && c <= 6) begin
        vectors++;
        if ({rf_write_enable, rf_rd} !== {1'b1, 5'(6 + c - 4)}) begin miscompares++; $display("FAIL bp_order[%0d] got we=%b rd=%0d want rd=%0d", c, rf_write_enable, rf_rd, 6 + c - 4); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 5'(15 + i); alu_data = 32'hD00D_0000 + 32'(i);
      #1;
      vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d] got %b want 1", i, alu_ready); end
      step();
      vectors++; if ({rf_write_enable, rf_rd} !== {1'b1, 5'(15 + i)}) begin miscompares++; $display("FAIL b2b_write[%0d] got we=%b rd=%0d", i, rf_write_enable, rf_rd); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1; issue_rd = 5'd10; rs1 = 5'd10; rs2 = 5'd10;
    #1;
    vectors++; if (issue_stall !== 1'b0) begin miscompares++; $display("FAIL sb_first_issue got %b want 0", issue_stall); end
    step();
    #1;
    vectors++; if ({rs1_busy, rs2_busy, issue_stall} !== 3'b111) begin miscompares++; $display("FAIL sb_busy_stall got %b want 111", {rs1_busy, rs2_busy, issue_stall}); end
    step();
    issue_valid = 0; alu_valid = 1; alu_rd = 5'd10; alu_data = 32'hCAFE;
    step();
    alu_valid = 0;
    vectors++; if ({rf_write_enable, rf_rd, rf_rd_in} !== {1'b1, 5'd10, 32'hCAFE}) begin miscompares++; $display("FAIL sb_commit got we=%b rd=%0d data=%h", rf_write_enable, rf_rd, rf_rd_in); end
    issue_valid = 1; issue_rd = 5'd11;
    #1;
    vectors++; if ({rs1_busy, issue_stall} !== 2'b10) begin miscompares++; $display("FAIL sb_busy_at_write got %b want 10", {rs1_busy, issue_stall}); end
    step();
    issue_valid = 0; rs2 = 5'd11;
    #1;
    vectors++; if ({rs1_busy, rs2_busy} !== 2'b01) begin miscompares++; $display("FAIL sb_clear_set got %b want 01", {rs1_busy, rs2_busy}); end
    lsu_valid = 1; lsu_rd = 5'd11; lsu_data = 32'h1111;
    step();
    lsu_valid = 0;
    step();
    vectors++; if (rs2_busy !== 1'b0) begin miscompares++; $display("FAIL sb_lsu_clear got %b want 0", rs2_busy); end
  endtask

  task automatic test_zero_reg();
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    #1;
    vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL zero_ready got %b want 1", alu_ready); end
    step();
    alu_valid = 0;
    vectors++; if (rf_write_enable !== 1'b0) begin miscompares++; $display("FAIL zero_we got %b want 0", rf_write_enable); end
    issue_valid = 1; issue_rd = 5'd0; rs1 = 5'd0;
    #1;
    vectors++; if ({issue_stall, rs1_busy} !== 2'b00) begin miscompares++; $display("FAIL zero_issue got %b want 00", {issue_stall, rs1_busy}); end
    step();
    issue_valid = 0;
    #1;
    vectors++; if (rs1_busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy got %b want 0", rs1_busy); end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      issue_valid = 1; issue_rd = 5'(1 + c);
      lsu_valid = 1; lsu_rd = 5'd12; lsu_data = 32'h1200 + 32'(c);
      alu_valid = 1; alu_rd = 5'(13 + c); alu_data = 32'h1300 + 32'(c);
      step();
    end
    idle_inputs(); reset = 1; rs1 = 5'd1;
    #1;
    vectors++; if ({alu_ready, rs1_busy} !== 2'b01) begin miscompares++; $display("FAIL mid_prereset got %b want 01", {alu_ready, rs1_busy}); end
    step();
    reset = 0;
    #1;
    vectors++; if ({rf_write_enable, alu_ready, rs1_busy} !== 3'b010) begin miscompares++; $display("FAIL mid_postreset got %b want 010", {rf_write_enable, alu_ready, rs1_busy}); end
    rs1 = 5'd2;
    #1;
    vectors++; if (rs1_busy !== 1'b0) begin miscompares++; $display("FAIL mid_x2_busy got %b want 0", rs1_busy); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (rf_write_enable !== 1'b0) begin miscompares++; $display("FAIL mid_discard[%0d] got we=%b rd=%0d", i, rf_write_enable, rf_rd); end
    end
  endtask

  task automatic test_random_mix();
    bit acc;
    alu_valid = 0;
    for (int c = 0; c < 80; c++) begin
      lsu_valid = ($urandom_range(0, 2) == 0);
      lsu_rd = 5'($urandom_range(0, 31)); lsu_data = $urandom;
      if (!alu_valid) begin
        alu_valid = ($urandom_range(0, 1) == 1);
        alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
      end
      #1;
      acc = alu_valid & alu_ready;
      step();
      if (acc) alu_valid = 0;
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_collision();
    test_back_pressure();
    test_back_to_back();
    test_scoreboard();
    test_zero_reg();
    test_reset_mid();
    test_random_mix();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/z_core_writeback.md
Name: z_core_writeback

Overview:
Writer side of the core register file. Collects results from the ALU (single-cycle) and the LSU (multi-cycle load returns) and arbitrates them onto the register file's single write port (rd / rd_in / write_enable). Holds a pending-write scoreboard over x1..x31 so decode can stall on RAW/WAW hazards. Sits between execute/LSU and z_core_reg_file.

Parameters:
XLEN, 32, data width of results and register file write data
FIFO_DEPTH, 2, ALU result buffer entries (power of two, >=2)

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
issue_valid  input  1  decode issues an instruction that writes issue_rd
issue_rd  input  5  destination register of issuing instruction
issue_stall  output  1  issue_valid & pending[issue_rd] & issue_rd!=0 (combinational)
rs1  input  5  decode source register 1 query
rs2  input  5  decode source register 2 query
rs1_busy  output  1  pending[rs1] & rs1!=0 (combinational)
rs2_busy  output  1  pending[rs2] & rs2!=0 (combinational)
alu_valid  input  1  ALU result valid
alu_ready  output  1  ALU result accepted this cycle
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
lsu_valid  input  1  load data valid
lsu_ready  output  1  constant 1; LSU is never back-pressured
lsu_rd  input  5  load destination register
lsu_data  input  XLEN  load data (already sign/zero-extended)
rf_rd  output  5  register file write address (registered)
rf_rd_in  output  XLEN  register file write data (registered)
rf_write_enable  output  1  register file write strobe (registered)

Behaviour:
- Reset (synchronous, active-high): FIFO empty (pointers and count 0), pending = 0, rf_write_enable=0, rf_rd=0, rf_rd_in=0. Reset mid-operation discards buffered ALU results and all pending bits; rf_write_enable is 0 at the edge after reset is sampled.
- alu_ready = (count < FIFO_DEPTH). ALU handshake completes when alu_valid & alu_ready.
- Commit select, evaluated each cycle, priority order:
  1. lsu_valid: commit {lsu_rd, lsu_data}.
  2. else FIFO non-empty: commit FIFO head, pop.
  3. else alu_valid (FIFO empty): bypass; commit {alu_rd, alu_data} directly, no enqueue.
  4. else no commit.
- An accepted ALU result not committed via bypass is enqueued at the tail. Simultaneous push and pop are legal; count unchanged. A push can never occur when full (alu_ready=0). ALU results commit strictly in acceptance order; bypass is allowed only when the FIFO is empty.
- Commit is registered. Next edge: rf_rd/rf_rd_in = committed rd/data, and rf_write_enable = (commit & rd!=0). With no commit, rf_write_enable=0 and rf_rd/rf_rd_in hold.
- Commits with rd=0 consume the slot/entry but never assert rf_write_enable and never touch pending.
- Latency: the LSU result and the bypassed ALU result appear on the rf_* outputs 1 cycle after acceptance. A buffered ALU result appears 1 cycle after it reaches the FIFO head and no LSU result is valid.
- Scoreboard pending[31:1]:
  - Set on the edge where issue_valid & !issue_stall & issue_rd!=0.
  - Cleared on the edge where rf_write_enable=1 for rf_rd, which is the same edge the register file writes. rs*_busy therefore drops exactly when the register file holds the new value.
  - Set and clear of the same index cannot coincide because issue_stall blocks issue to a pending rd. A set of index A and a clear of index B in the same cycle both take effect.
- Results for a register that is not pending are still written. No protocol check is performed.

Test Plan:
- Reset, then single ALU result: alu_valid=1, alu_rd=5, alu_data=0x1234 for 1 cycle with FIFO empty -> alu_ready=1; next cycle rf_write_enable=1, rf_rd=5, rf_rd_in=0x1234; the following cycle rf_write_enable=0.
- Collision: lsu_valid (rd=3, 0xAAAA0000) and alu_valid (rd=4, 0x55) in the same cycle -> cycle+1 writes x3=0xAAAA0000; cycle+2 writes x4=0x55 from the FIFO.
- Back-pressure: lsu_valid held for 4 cycles while the ALU presents rd=6,7,8 -> alu_ready=1,1,0 (FIFO_DEPTH=2 full); after lsu_valid drops, x6 then x7 then x8 are written in order on consecutive cycles, with no loss or duplication.
- Scoreboard: issue rd=10 -> next cycle rs1=10 gives rs1_busy=1; issue rd=10 again gives issue_stall=1; an ALU result for rd=10 commits -> busy clears on the edge with rf_write_enable=1, rf_rd=10.
- Zero register: ALU result rd=0, data=0xFFFFFFFF -> alu_ready=1, rf_write_enable stays 0; issue rd=0 leaves issue_stall=0 and rs1_busy=0 for rs1=0.
- Reset mid-operation: FIFO holding 2 entries and pending={x1,x2}, assert reset for 1 cycle -> rf_write_enable=0, alu_ready=1, rs1_busy=0 for rs1=1 and rs1=2; the discarded entries are never written.
